nms_thresh_pipe: RTL and testbench
==================================

Name: nms_thresh_pipe

Overview:
- Parametrised, streaming successor to the single-cycle non-maximum suppression stage of the Canny edge pipeline.
- Accepts one 3x3 gradient window plus a quantised direction per beat under valid/ready. Applies suppression with selectable tie handling, then classifies survivors against double thresholds (strong/weak/none) for the hysteresis stage.
- Keeps per-frame strong/weak pixel counts for auto-threshold firmware.
- Sits between the gradient/angle stage and the hysteresis linker.

Parameters:
- DW, 8, gradient magnitude width in bits.
- CNTW, 20, width of per-frame statistic counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept input this cycle
- i_grad  in  9*DW  window; element k at bits [9*DW-1-k*DW -: DW]; layout 0 1 2 / 3 4 5 / 6 7 8; centre = 4
- i_angle  in  2  00 vertical(1,7), 01 diag /(2,6), 10 horizontal(3,5), 11 diag \(0,8)
- i_sof  in  1  first beat of frame
- i_eof  in  1  last beat of frame
- i_thr_hi  in  DW  strong threshold
- i_thr_lo  in  DW  weak threshold
- i_tie_mode  in  1  0: suppress if a neighbour is greater than the centre; 1: suppress if a neighbour is greater than or equal to the centre
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_pixel  out  DW  centre if kept, else 0
- o_class  out  2  00 none, 01 weak, 10 strong; 11 never driven
- o_eof  out  1  eof aligned with o_pixel
- o_strong_cnt  out  CNTW  strong count of last completed frame
- o_weak_cnt  out  CNTW  weak count of last completed frame
- o_cnt_valid  out  1  one-cycle pulse when counts update

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; the clock is i_clk.
  - All pipeline valids, o_pixel, o_class, o_eof, counters, o_strong_cnt, o_weak_cnt, o_cnt_valid and latched thresholds reset to 0.
  - A reset mid-frame drops in-flight beats. Counting restarts only at the next i_sof.
- Pipeline: two register stages, S1 (suppression) and S2 (classification).
  - Global advance = !o_valid || i_ready. o_ready = advance. Input is accepted when i_valid && o_ready.
  - Latency is 2 cycles from accepted input to o_valid with no backpressure. Throughput is 1 beat/cycle.
  - While o_valid && !i_ready, o_pixel, o_class and o_eof are held stable, and S1 also holds.
  - Bubbles (i_valid=0) propagate as S1/S2 valid=0.
- S1: compare the two neighbours selected by i_angle against the centre, per i_tie_mode. Register the kept pixel, sof and eof.
  - i_tie_mode is sampled per beat.
- Thresholds: i_thr_hi and i_thr_lo are latched on each accepted sof beat and used for that whole frame. Changes mid-frame are ignored.
  - If latched lo > hi, the effective lo = hi, so no weak class is possible.
  - Before the first sof after reset, the thresholds are 0.
- S2 classification on the kept pixel p:
  - p == 0 -> none.
  - else p >= hi -> strong.
  - else p >= lo -> weak.
  - else none, with o_pixel still = p.
- Statistics are updated on the output handshake (o_valid && i_ready):
  - A sof beat clears the running counters before counting itself.
  - strong/weak counts increment per class and saturate at 2^CNTW-1.
  - An eof beat copies the final counts (including itself) to o_strong_cnt/o_weak_cnt and pulses o_cnt_valid the next cycle.
  - sof and eof on the same beat form a 1-pixel frame: counts are 0/1 accordingly.
  - A missing sof means counting continues from the prior value.

Decomposition:
- Package nms_pkg holds:
  - class typedef enum (CLS_NONE, CLS_WEAK, CLS_STRONG);
  - angle typedef enum (ANG_VERT, ANG_DIAG_R, ANG_HORZ, ANG_DIAG_L);
  - window index constants (W_C=4 and the neighbour pairs).
- Sub-module nms_frame_stats: saturating counters, sof clear, eof latch and pulse. Driven by the handshake, class, sof and eof.

Test Plan:
- DW=8, window centre 50, neighbours (1,7) = 40/60, angle 00 -> o_pixel 0, class none, o_valid exactly 2 cycles after accept.
- Centre 50, neighbours 50/30, angle 10, tie_mode 0 -> pixel 50. Same with tie_mode 1 -> pixel 0.
- sof beat with hi=100, lo=40; pixels 120, 60, 20 kept. Change hi to 10 mid-frame -> classes strong, weak, none (latched thresholds used).
- Hold i_ready=0 for 5 cycles with 3 beats offered:
  - o_ready goes 0 once the pipeline is full;
  - o_pixel/o_class stay stable;
  - all beats are delivered in order with no loss or duplication.
- 4-beat frame with classes strong, weak, strong, none -> on the eof handshake, o_strong_cnt=2, o_weak_cnt=1, one-cycle o_cnt_valid.
- Assert i_rst_n low with 2 beats in flight -> o_valid=0 and counts 0 immediately. Next frame counts are correct.

Source files
------------

// File: rtl/nms_pkg.sv
// Shared types and window geometry for the NMS / double-threshold pipe.
// Exports: cls_e, ang_e, window index constants.
package nms_pkg;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'b00,
    CLS_WEAK   = 2'b01,
    CLS_STRONG = 2'b10
  } cls_e;

  typedef enum logic [1:0] {
    ANG_VERT   = 2'b00,
    ANG_DIAG_R = 2'b01,
    ANG_HORZ   = 2'b10,
    ANG_DIAG_L = 2'b11
  } ang_e;

  // 3x3 layout: 0 1 2 / 3 4 5 / 6 7 8
  localparam int unsigned W_C      = 4;
  localparam int unsigned W_VERT_A = 1;
  localparam int unsigned W_VERT_B = 7;
  localparam int unsigned W_DR_A   = 2;
  localparam int unsigned W_DR_B   = 6;
  localparam int unsigned W_HORZ_A = 3;
  localparam int unsigned W_HORZ_B = 5;
  localparam int unsigned W_DL_A   = 0;
  localparam int unsigned W_DL_B   = 8;

endpackage

// File: rtl/nms_frame_stats.sv
// Per-frame strong/weak counters: saturate, clear on sof, publish on eof.
// Ports: i_hs/i_class/i_sof/i_eof in; o_strong_cnt, o_weak_cnt, o_cnt_valid out.
module nms_frame_stats
  import nms_pkg::*;
#(
  parameter int unsigned CNTW = 20
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_hs,
  input  cls_e            i_class,
  input  logic            i_sof,
  input  logic            i_eof,
  output logic [CNTW-1:0] o_strong_cnt,
  output logic [CNTW-1:0] o_weak_cnt,
  output logic            o_cnt_valid
);

  localparam logic [CNTW-1:0] CMAX = '1;

  logic [CNTW-1:0] strong_q, strong_d;
  logic [CNTW-1:0] weak_q, weak_d;
  logic [CNTW-1:0] out_s_q, out_s_d;
  logic [CNTW-1:0] out_w_q, out_w_d;
  logic            pulse_q, pulse_d;
  logic [CNTW-1:0] base_s, base_w;
  logic            inc_s, inc_w;

  always_comb begin
    // sof restarts the frame before this beat counts
    base_s   = i_sof ? '0 : strong_q;
    base_w   = i_sof ? '0 : weak_q;
    inc_s    = (i_class == CLS_STRONG)
               && (base_s != CMAX);
    inc_w    = (i_class == CLS_WEAK)
               && (base_w != CMAX);
    strong_d = strong_q;
    weak_d   = weak_q;
    out_s_d  = out_s_q;
    out_w_d  = out_w_q;
    pulse_d  = 1'b0;
    if (i_hs) begin
      strong_d = base_s
               + {{(CNTW-1){1'b0}}, inc_s};
      weak_d   = base_w
               + {{(CNTW-1){1'b0}}, inc_w};
      if (i_eof) begin
        out_s_d = strong_d;
        out_w_d = weak_d;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strong_q <= '0;
      weak_q   <= '0;
      out_s_q  <= '0;
      out_w_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      strong_q <= strong_d;
      weak_q   <= weak_d;
      out_s_q  <= out_s_d;
      out_w_q  <= out_w_d;
      pulse_q  <= pulse_d;
    end
  end

  assign o_strong_cnt = out_s_q;
  assign o_weak_cnt   = out_w_q;
  assign o_cnt_valid  = pulse_q;

endmodule

// File: rtl/nms_thresh_pipe.sv
// Streaming NMS + double threshold: S1 suppression, S2 classification.
// Ports: valid/ready window input, valid/ready pixel/class output, frame stats.
module nms_thresh_pipe
  import nms_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned CNTW = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [9*DW-1:0]   i_grad,
  input  logic [1:0]        i_angle,
  input  logic              i_sof,
  input  logic              i_eof,
  input  logic [DW-1:0]     i_thr_hi,
  input  logic [DW-1:0]     i_thr_lo,
  input  logic              i_tie_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DW-1:0]     o_pixel,
  output logic [1:0]        o_class,
  output logic              o_eof,
  output logic [CNTW-1:0]   o_strong_cnt,
  output logic [CNTW-1:0]   o_weak_cnt,
  output logic              o_cnt_valid
);

  logic [DW-1:0] win [9];

  for (genvar k = 0; k < 9; k++) begin : g_win
    assign win[k] = i_grad[9*DW-1-k*DW -: DW];
  end

  logic adv, acc;
  logic s2_valid_q, s2_valid_d;

  // one global stall: everything moves only when the output frees
  assign adv     = !s2_valid_q || i_ready;
  assign o_ready = adv;
  assign acc     = i_valid && adv;

  ang_e          ang;
  logic [DW-1:0] ctr, nb_a, nb_b;
  logic          supp;
  logic [DW-1:0] kept;

  assign ang = ang_e'(i_angle);
  assign ctr = win[W_C];

  always_comb begin
    nb_a = win[W_VERT_A];
    nb_b = win[W_VERT_B];
    unique case (1'b1)
      (ang == ANG_VERT): begin
        nb_a = win[W_VERT_A];
        nb_b = win[W_VERT_B];
      end
      (ang == ANG_DIAG_R): begin
        nb_a = win[W_DR_A];
        nb_b = win[W_DR_B];
      end
      (ang == ANG_HORZ): begin
        nb_a = win[W_HORZ_A];
        nb_b = win[W_HORZ_B];
      end
      (ang == ANG_DIAG_L): begin
        nb_a = win[W_DL_A];
        nb_b = win[W_DL_B];
      end
    endcase
  end

  always_comb begin
    if (i_tie_mode)
      supp = (nb_a >= ctr) || (nb_b >= ctr);
    else
      supp = (nb_a > ctr) || (nb_b > ctr);
    kept = supp ? '0 : ctr;
  end

  // S1
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_pix_q, s1_pix_d;
  logic          s1_sof_q, s1_sof_d;
  logic          s1_eof_q, s1_eof_d;
  logic [DW-1:0] thr_hi_q, thr_hi_d;
  logic [DW-1:0] thr_lo_q, thr_lo_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_sof_d   = s1_sof_q;
    s1_eof_d   = s1_eof_q;
    if (adv) begin
      s1_valid_d = i_valid;
      s1_pix_d   = kept;
      s1_sof_d   = i_sof;
      s1_eof_d   = i_eof;
    end
  end

  // thresholds become visible together with the sof beat in S1
  always_comb begin
    thr_hi_d = thr_hi_q;
    thr_lo_d = thr_lo_q;
    if (acc && i_sof) begin
      thr_hi_d = i_thr_hi;
      thr_lo_d = i_thr_lo;
    end
  end

  // S2
  logic [DW-1:0] lo_eff;
  cls_e          cls_new;

  always_comb begin
    lo_eff = (thr_lo_q > thr_hi_q) ? thr_hi_q
                                   : thr_lo_q;
    if (s1_pix_q == '0)
      cls_new = CLS_NONE;
    else if (s1_pix_q >= thr_hi_q)
      cls_new = CLS_STRONG;
    else if (s1_pix_q >= lo_eff)
      cls_new = CLS_WEAK;
    else
      cls_new = CLS_NONE;
  end

  logic [DW-1:0] s2_pix_q, s2_pix_d;
  cls_e          s2_cls_q, s2_cls_d;
  logic          s2_sof_q, s2_sof_d;
  logic          s2_eof_q, s2_eof_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_pix_d   = s2_pix_q;
    s2_cls_d   = s2_cls_q;
    s2_sof_d   = s2_sof_q;
    s2_eof_d   = s2_eof_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      s2_pix_d   = s1_pix_q;
      s2_cls_d   = cls_new;
      s2_sof_d   = s1_sof_q;
      s2_eof_d   = s1_eof_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_sof_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      thr_hi_q   <= '0;
      thr_lo_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_pix_q   <= '0;
      s2_cls_q   <= CLS_NONE;
      s2_sof_q   <= 1'b0;
      s2_eof_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pix_q   <= s1_pix_d;
      s1_sof_q   <= s1_sof_d;
      s1_eof_q   <= s1_eof_d;
      thr_hi_q   <= thr_hi_d;
      thr_lo_q   <= thr_lo_d;
      s2_valid_q <= s2_valid_d;
      s2_pix_q   <= s2_pix_d;
      s2_cls_q   <= s2_cls_d;
      s2_sof_q   <= s2_sof_d;
      s2_eof_q   <= s2_eof_d;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_pixel = s2_pix_q;
  assign o_class = s2_cls_q;
  assign o_eof   = s2_eof_q;

  nms_frame_stats #(
    .CNTW(CNTW)
  ) u_stats (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_hs         (s2_valid_q && i_ready),
    .i_class      (s2_cls_q),
    .i_sof        (s2_sof_q),
    .i_eof        (s2_eof_q),
    .o_strong_cnt (o_strong_cnt),
    .o_weak_cnt   (o_weak_cnt),
    .o_cnt_valid  (o_cnt_valid)
  );

endmodule

// File: tb/tb_nms_thresh_pipe.sv
// Bench for nms_thresh_pipe: vector table, corner sequences, random stream.
// Checks against a queue-based reference of the suppression/threshold rules.
module tb_nms_thresh_pipe;

  localparam int DW   = 8;
  localparam int CNTW = 4;
  localparam int MAXC = (1 << CNTW) - 1;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic            i_rst_n;
  logic            i_valid, o_ready;
  logic [71:0]     i_grad;
  logic [1:0]      i_angle;
  logic            i_sof, i_eof;
  logic [7:0]      i_thr_hi, i_thr_lo;
  logic            i_tie_mode;
  logic            o_valid, i_ready;
  logic [7:0]      o_pixel;
  logic [1:0]      o_class;
  logic            o_eof;
  logic [CNTW-1:0] o_strong_cnt, o_weak_cnt;
  logic            o_cnt_valid;

  nms_thresh_pipe #(
    .DW(DW),
    .CNTW(CNTW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_grad       (i_grad),
    .i_angle      (i_angle),
    .i_sof        (i_sof),
    .i_eof        (i_eof),
    .i_thr_hi     (i_thr_hi),
    .i_thr_lo     (i_thr_lo),
    .i_tie_mode   (i_tie_mode),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_pixel      (o_pixel),
    .o_class      (o_class),
    .o_eof        (o_eof),
    .o_strong_cnt (o_strong_cnt),
    .o_weak_cnt   (o_weak_cnt),
    .o_cnt_valid  (o_cnt_valid)
  );

  typedef struct packed {
    logic        v;
    logic [71:0] g;
    logic [1:0]  ang;
    logic        tie, sof, eof;
    logic [7:0]  hi, lo;
  } beat_t;

  typedef struct packed {
    logic [7:0] pix;
    logic [1:0] cls;
    logic       sof, eof;
  } exp_t;

  typedef struct packed {
    logic [7:0] c, a, b;
    logic [1:0] ang;
    logic       tie;
    logic [7:0] hi, lo, pix;
    logic [1:0] cls;
  } vec_t;

  int         n_chk, n_fail, pulses;
  exp_t       q_exp[$];
  logic [9:0] got[$];
  logic [7:0] m_hi, m_lo;
  int         m_s, m_w, x_s, x_w;
  logic       acc_l;
  beat_t      idle_b;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int pa(input logic [1:0] ang);
    case (ang)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int pb(input logic [1:0] ang);
    return 8 - pa(ang);
  endfunction

  function automatic logic [71:0] mkgrad(
      input logic [7:0] c, a, b,
      input logic [1:0] ang);
    logic [71:0] g;
    g = '1;
    g[39:32] = c;
    g[71-8*pa(ang) -: 8] = a;
    g[71-8*pb(ang) -: 8] = b;
    return g;
  endfunction

  function automatic logic [7:0] ref_keep(
      input logic [71:0] g,
      input logic [1:0] ang,
      input logic tie);
    logic [7:0] c, a, b;
    c = g[39:32];
    a = g[71-8*pa(ang) -: 8];
    b = g[71-8*pb(ang) -: 8];
    if (tie) return (a >= c || b >= c) ? 8'd0 : c;
    return (a > c || b > c) ? 8'd0 : c;
  endfunction

  function automatic logic [1:0] ref_cls(
      input logic [7:0] p, hi, lo);
    if (p == 0) return 2'b00;
    if (p >= hi) return 2'b10;
    if (p >= lo) return 2'b01;
    return 2'b00;
  endfunction

  function automatic beat_t bt(
      input logic [7:0] c,
      input logic sof, eof,
      input logic [7:0] hi, lo);
    beat_t b;
    b.v = 1'b1;
    b.g = mkgrad(c, 8'd0, 8'd0, 2'd0);
    b.ang = 2'd0;
    b.tie = 1'b0;
    b.sof = sof;
    b.eof = eof;
    b.hi = hi;
    b.lo = lo;
    return b;
  endfunction

  task automatic cycle(input beat_t b,
                       input logic rdy,
                       output logic acc);
    logic hs, hold, pls, he;
    logic [7:0] hp, kp;
    logic [1:0] hc;
    exp_t e;
    @(negedge i_clk);
    i_valid = b.v;
    i_grad = b.g;
    i_angle = b.ang;
    i_tie_mode = b.tie;
    i_sof = b.sof;
    i_eof = b.eof;
    i_thr_hi = b.hi;
    i_thr_lo = b.lo;
    i_ready = rdy;
    #1;
    acc = i_valid && o_ready;
    hs = o_valid && i_ready;
    pls = 1'b0;
    chk("o_ready", o_ready, !o_valid || i_ready);
    if (hs) begin
      if (q_exp.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = q_exp.pop_front();
        chk("pixel", o_pixel, e.pix);
        chk("class", o_class, e.cls);
        chk("eof", o_eof, e.eof);
        got.push_back({o_pixel, o_class});
        if (e.sof) begin
          m_s = 0;
          m_w = 0;
        end
        if (e.cls == 2'b10 && m_s < MAXC) m_s++;
        if (e.cls == 2'b01 && m_w < MAXC) m_w++;
        if (e.eof) begin
          x_s = m_s;
          x_w = m_w;
          pls = 1'b1;
        end
      end
    end
    hold = o_valid && !i_ready;
    hp = o_pixel;
    hc = o_class;
    he = o_eof;
    if (acc) begin
      if (b.sof) begin
        m_hi = b.hi;
        m_lo = b.lo;
      end
      kp = ref_keep(b.g, b.ang, b.tie);
      e.pix = kp;
      e.cls = ref_cls(kp, m_hi, m_lo);
      e.sof = b.sof;
      e.eof = b.eof;
      q_exp.push_back(e);
    end
    @(posedge i_clk);
    #1;
    if (o_cnt_valid) pulses++;
    chk("cnt_valid", o_cnt_valid, pls);
    chk("strong_cnt", o_strong_cnt, x_s);
    chk("weak_cnt", o_weak_cnt, x_w);
    if (hold) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_pixel", o_pixel, hp);
      chk("hold_class", o_class, hc);
      chk("hold_eof", o_eof, he);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(idle_b, 1'b1, acc_l);
  endtask

  vec_t tbl[11];

  initial begin
    int idx, p0;
    beat_t bp[3];
    beat_t rb;
    n_chk = 0;
    n_fail = 0;
    pulses = 0;
    m_hi = 0;
    m_lo = 0;
    m_s = 0;
    m_w = 0;
    x_s = 0;
    x_w = 0;
    idle_b = '0;

    tbl[0]  = {8'd50, 8'd40, 8'd60, 2'd0, 1'b0,
               8'd100, 8'd40, 8'd0, 2'b00};
    tbl[1]  = {8'd50, 8'd50, 8'd30, 2'd2, 1'b0,
               8'd100, 8'd40, 8'd50, 2'b01};
    tbl[2]  = {8'd50, 8'd50, 8'd30, 2'd2, 1'b1,
               8'd100, 8'd40, 8'd0, 2'b00};
    tbl[3]  = {8'd120, 8'd10, 8'd20, 2'd1, 1'b0,
               8'd100, 8'd40, 8'd120, 2'b10};
    tbl[4]  = {8'd30, 8'd30, 8'd30, 2'd3, 1'b0,
               8'd100, 8'd40, 8'd30, 2'b00};
    tbl[5]  = {8'd60, 8'd61, 8'd0, 2'd3, 1'b1,
               8'd100, 8'd40, 8'd0, 2'b00};
    tbl[6]  = {8'd0, 8'd0, 8'd0, 2'd0, 1'b0,
               8'd0, 8'd0, 8'd0, 2'b00};
    tbl[7]  = {8'd100, 8'd99, 8'd99, 2'd2, 1'b1,
               8'd100, 8'd40, 8'd100, 2'b10};
    tbl[8]  = {8'd40, 8'd39, 8'd0, 2'd1, 1'b1,
               8'd100, 8'd40, 8'd40, 2'b01};
    tbl[9]  = {8'd45, 8'd0, 8'd0, 2'd0, 1'b0,
               8'd50, 8'd70, 8'd45, 2'b00};
    tbl[10] = {8'd1, 8'd0, 8'd0, 2'd3, 1'b1,
               8'd0, 8'd0, 8'd1, 2'b10};

    i_rst_n = 1'b0;
    i_valid = 0;
    i_grad = '0;
    i_angle = 0;
    i_sof = 0;
    i_eof = 0;
    i_thr_hi = 0;
    i_thr_lo = 0;
    i_tie_mode = 0;
    i_ready = 1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_pixel", o_pixel, 0);
    chk("rst_class", o_class, 0);
    chk("rst_eof", o_eof, 0);
    chk("rst_strong", o_strong_cnt, 0);
    chk("rst_weak", o_weak_cnt, 0);
    chk("rst_cnt_valid", o_cnt_valid, 0);
    chk("rst_ready", o_ready, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // single-beat frames from the table, latency 2
    foreach (tbl[i]) begin
      rb.v = 1'b1;
      rb.g = mkgrad(tbl[i].c, tbl[i].a,
                    tbl[i].b, tbl[i].ang);
      rb.ang = tbl[i].ang;
      rb.tie = tbl[i].tie;
      rb.sof = 1'b1;
      rb.eof = 1'b1;
      rb.hi = tbl[i].hi;
      rb.lo = tbl[i].lo;
      cycle(rb, 1'b1, acc_l);
      chk("tbl_accept", acc_l, 1);
      chk("tbl_lat1", o_valid, 0);
      cycle(idle_b, 1'b1, acc_l);
      chk("tbl_lat2", o_valid, 1);
      chk("tbl_pixel", o_pixel, tbl[i].pix);
      chk("tbl_class", o_class, tbl[i].cls);
      cycle(idle_b, 1'b1, acc_l);
    end

    // thresholds latched on sof, mid-frame change ignored
    got.delete();
    cycle(bt(8'd120, 1, 0, 8'd100, 8'd40), 1, acc_l);
    cycle(bt(8'd60, 0, 0, 8'd10, 8'd5), 1, acc_l);
    cycle(bt(8'd20, 0, 1, 8'd10, 8'd5), 1, acc_l);
    idle(3);
    chk("thr_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("thr_b0", got[0], {8'd120, 2'b10});
      chk("thr_b1", got[1], {8'd60, 2'b01});
      chk("thr_b2", got[2], {8'd20, 2'b00});
    end
    chk("thr_strong", o_strong_cnt, 1);
    chk("thr_weak", o_weak_cnt, 1);

    // backpressure: 5 stalled cycles, 3 beats offered
    got.delete();
    bp[0] = bt(8'd11, 1, 0, 8'd20, 8'd5);
    bp[1] = bt(8'd22, 0, 0, 8'd0, 8'd0);
    bp[2] = bt(8'd33, 0, 1, 8'd0, 8'd0);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(idx < 3 ? bp[idx] : idle_b, 1'b0, acc_l);
      if (acc_l) idx++;
      if (c >= 1) chk("bp_ready_low", o_ready, 0);
    end
    chk("bp_accepted", idx, 2);
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      cycle(idx < 3 ? bp[idx] : idle_b, 1'b1, acc_l);
      if (acc_l) idx++;
    end
    chk("bp_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_b0", got[0], {8'd11, 2'b01});
      chk("bp_b1", got[1], {8'd22, 2'b10});
      chk("bp_b2", got[2], {8'd33, 2'b10});
    end

    // 4-beat frame: strong, weak, strong, none
    p0 = pulses;
    cycle(bt(8'd120, 1, 0, 8'd100, 8'd40), 1, acc_l);
    cycle(bt(8'd60, 0, 0, 8'd0, 8'd0), 1, acc_l);
    cycle(bt(8'd200, 0, 0, 8'd0, 8'd0), 1, acc_l);
    cycle(bt(8'd10, 0, 1, 8'd0, 8'd0), 1, acc_l);
    idle(4);
    chk("f4_pulses", pulses - p0, 1);
    chk("f4_strong", o_strong_cnt, 2);
    chk("f4_weak", o_weak_cnt, 1);

    // long frame saturates the strong counter
    for (int i = 0; i < 20; i++)
      cycle(bt(8'd200, i == 0, i == 19,
               8'd100, 8'd40), 1, acc_l);
    idle(3);
    chk("sat_strong", o_strong_cnt, MAXC);
    chk("sat_weak", o_weak_cnt, 0);

    // reset with two beats in flight
    cycle(bt(8'd90, 1, 0, 8'd50, 8'd10), 1, acc_l);
    cycle(bt(8'd30, 0, 0, 8'd50, 8'd10), 1, acc_l);
    chk("pre_rst_valid", o_valid, 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_strong", o_strong_cnt, 0);
    chk("mid_rst_weak", o_weak_cnt, 0);
    chk("mid_rst_pulse", o_cnt_valid, 0);
    q_exp.delete();
    m_hi = 0;
    m_lo = 0;
    m_s = 0;
    m_w = 0;
    x_s = 0;
    x_w = 0;
    #1;
    i_rst_n = 1'b1;
    got.delete();
    cycle(bt(8'd5, 0, 0, 8'd200, 8'd200), 1, acc_l);
    idle(2);
    chk("rst_thr0", got.size() == 1 ? got[0] : '0,
        {8'd5, 2'b10});
    cycle(bt(8'd120, 1, 0, 8'd100, 8'd40), 1, acc_l);
    cycle(bt(8'd60, 0, 0, 8'd0, 8'd0), 1, acc_l);
    cycle(bt(8'd120, 0, 1, 8'd0, 8'd0), 1, acc_l);
    idle(3);
    chk("post_rst_strong", o_strong_cnt, 2);
    chk("post_rst_weak", o_weak_cnt, 1);

    // random traffic against the reference queue
    for (int i = 0; i < 3000; i++) begin
      rb.v = ($urandom % 4) != 0;
      for (int k = 0; k < 9; k++)
        rb.g[71-8*k -: 8] = 8'($urandom_range(0, 7) * 32);
      rb.ang = 2'($urandom);
      rb.tie = 1'($urandom);
      rb.sof = ($urandom % 10) == 0;
      rb.eof = ($urandom % 8) == 0;
      rb.hi = 8'($urandom_range(0, 7) * 32);
      rb.lo = 8'($urandom_range(0, 7) * 32);
      cycle(rb, ($urandom % 4) != 0, acc_l);
    end
    for (int i = 0; i < 10 && q_exp.size() != 0; i++)
      cycle(idle_b, 1'b1, acc_l);
    chk("drain_empty", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
